dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port C (pipeline load/store
//  unit) and port D (DMA / debug loader). One access per clock is granted; reads return
//  a registered response one cycle after grant. Sits between the requesters and dmem,
//  driving dmem's we/a/wd and sampling its combinational rd.
// PARAMETERS
//  AW        32  address width (byte address; memory word index = addr[AW-1:2])
//  DW        32  data width
//  CPU_PRIO  0   0 = round-robin between C and D; 1 = fixed priority, C always wins
//  MAX_LOCK  8   max consecutive locked grants to D (>=1)
// PORTS
//  clk       in   1   clock, all state on posedge
//  reset     in   1   synchronous reset, active-high
//  c_req     in   1   C requests an access this cycle
//  c_we      in   1   C access is a write
//  c_addr    in   AW  C byte address
//  c_wdata   in   DW  C write data
//  c_gnt     out  1   C access accepted this cycle (combinational)
//  c_rvalid  out  1   C read data valid (registered)
//  c_rdata   out  DW  C read data
//  d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata  as C, for port D
//  d_lock    in   1   D requests exclusive bus ownership for a burst
//  mem_we    out  1   to dmem we
//  mem_a     out  AW  to dmem a
//  mem_wd    out  DW  to dmem wd
//  mem_rd    in   DW  from dmem rd (combinational read of mem_a)
// BEHAVIOUR
//  - Reset (while reset=1 and the cycle after): c_gnt=d_gnt=0, mem_we=0, c/d_rvalid=0,
//    c/d_rdata=0, state=ARB, last_gnt=D (C wins first tie), lock_cnt=0.
//  - Handshake: access completes in the cycle where req & gnt. Requester holds req/we/
//    addr/wdata stable until gnt. At most one of c_gnt/d_gnt is 1; gnt never without req.
//  - ARB state: only one req -> grant it. Both -> CPU_PRIO=1: C; CPU_PRIO=0: the port
//    not in last_gnt. last_gnt updates on every grant.
//  - LOCK_D state: entered at the edge after a D grant with d_lock=1 (lock_cnt<=1).
//    While d_req&d_lock and lock_cnt<MAX_LOCK: D granted, C blocked, lock_cnt++.
//    If d_lock=0 or d_req=0: cycle arbitrates as ARB, state<=ARB, lock_cnt<=0.
//    If lock_cnt==MAX_LOCK: forced release; that cycle C wins if c_req (else D may be
//    granted as ARB), state<=ARB, and D cannot re-lock in the same cycle.
//  - Mux: mem_a/mem_wd from granted port (C when none granted); mem_we = gnt & we of
//    granted port, 0 when no grant. Write lands in dmem at the grant edge.
//  - Reads: granted read captures mem_rd at the grant edge; x_rvalid=1 for exactly the
//    next cycle, x_rdata=captured word. x_rdata holds its value until the next read
//    response of that port. Writes produce no rvalid.
//  - Latency: grant 0 cycles (same cycle as req when free), read data 1 cycle.
//  - Back-to-back: a port may be granted every cycle; write then read same address on
//    consecutive cycles returns the new data.
//  - Address: passed through unmodified; word select is dmem's job; no alignment check.
//  - Reset mid-burst: LOCK_D abandoned, pending rvalid dropped, no write issued while
//    reset=1.
// TESTING
//  1 reset=1 with c_req=d_req=1, we=1 -> no gnt, mem_we=0; after release rvalid=0.
//  2 CPU_PRIO=0, both read every cycle -> grants C,D,C,D...; each rvalid 1 cycle later.
//  3 C writes 0xDEADBEEF @0x10 then reads @0x10 next cycle -> c_rdata=0xDEADBEEF.
//  4 MAX_LOCK=4, D locked burst + C requesting -> 4 D grants, then C granted.
//  5 d_lock drops after 2 grants -> C granted next cycle; state back to ARB.
//  6 reset pulsed during D burst -> no gnt/we that cycle; first tie after goes to C.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: C (load/store unit) and D (DMA/debug).
// D may lock the bus for bounded bursts; read data returns one cycle after grant.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int CPU_PRIO = 0,
    parameter int MAX_LOCK = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    input  logic          i_d_lock,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_a,
    output logic [DW-1:0] o_mem_wd,
    input  logic [DW-1:0] i_mem_rd
);

    // state  | meaning
    // ARB    | normal arbitration between C and D
    // LOCK_D | D owns the bus for a locked burst, C blocked until release
    typedef enum logic {ARB = 1'b0, LOCK_D = 1'b1} state_t;

    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

    state_t          r_state;
    logic            r_last_d;
    logic [LCW-1:0]  r_lock_cnt;
    logic            r_c_rvalid;
    logic            r_d_rvalid;
    logic [DW-1:0]   r_c_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic            w_lock_hold;
    logic            w_forced;
    logic            w_c_gnt;
    logic            w_d_gnt;

    assign w_lock_hold = (r_state == LOCK_D) && i_d_req && i_d_lock && (r_lock_cnt < LOCK_MAX);
    assign w_forced    = (r_state == LOCK_D) && (r_lock_cnt == LOCK_MAX);

    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (i_reset) begin
            w_c_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end else if (w_lock_hold) begin
            w_d_gnt = 1'b1;
        end else if (w_forced && i_c_req) begin
            // lock budget exhausted: C gets the cycle ahead of any tie-break
            w_c_gnt = 1'b1;
        end else if (i_c_req && i_d_req) begin
            if (CPU_PRIO != 0 || r_last_d) begin
                w_c_gnt = 1'b1;
            end else begin
                w_d_gnt = 1'b1;
            end
        end else begin
            w_c_gnt = i_c_req;
            w_d_gnt = i_d_req;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ARB;
            r_last_d   <= 1'b1;
            r_lock_cnt <= '0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_c_gnt) begin
                r_last_d <= 1'b0;
            end else if (w_d_gnt) begin
                r_last_d <= 1'b1;
            end

            // a lock may only start from ARB, so a forced release cannot re-lock
            if (w_lock_hold) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end else if (r_state == ARB && w_d_gnt && i_d_lock) begin
                r_state    <= LOCK_D;
                r_lock_cnt <= LCW'(1);
            end else begin
                r_state    <= ARB;
                r_lock_cnt <= '0;
            end

            r_c_rvalid <= w_c_gnt && !i_c_we;
            r_d_rvalid <= w_d_gnt && !i_d_we;
            if (w_c_gnt && !i_c_we) begin
                r_c_rdata <= i_mem_rd;
            end
            if (w_d_gnt && !i_d_we) begin
                r_d_rdata <= i_mem_rd;
            end
        end
    end

    assign o_c_gnt    = w_c_gnt;
    assign o_d_gnt    = w_d_gnt;
    assign o_mem_a    = w_d_gnt ? i_d_addr  : i_c_addr;
    assign o_mem_wd   = w_d_gnt ? i_d_wdata : i_c_wdata;
    assign o_mem_we   = (w_c_gnt && i_c_we) || (w_d_gnt && i_d_we);
    assign o_c_rvalid = r_c_rvalid;
    assign o_d_rvalid = r_d_rvalid;
    assign o_c_rdata  = r_c_rdata;
    assign o_d_rdata  = r_d_rdata;

endmodule
